pf_vscroll_ctrl: RTL and testbench

//   Drives the control side of the playfield vertical-scroll counter chain (cascaded 4-bit
//   up/down counters with active-low load and count-enable). Holds a CPU-written scroll

---
 rtl/pf_vscroll_ctrl.sv | 148 ++++++++++++++
 tb/tb_pf_vscroll_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pf_vscroll_ctrl.sv
// pf_vscroll_ctrl: control side of the playfield vertical-scroll counter chain.
//   Shadows a CPU-written scroll value/direction, presets the cascaded 4-bit
//   counters once per frame at vblank start, then pulses count-enable once per
//   scanline. Flags wrap-around from the chain's max/min terminal output.
// Ports: clk/reset (sync, active-high); cpu_we/cpu_wdata/cpu_dir (shadow write);
//   vblank, line_tick, max_min (timing + chain status in); load_n, cten_n, du,
//   preset (counter chain controls); pending, wrap_seen (status).
// Optional: define VSCROLL_READBACK_EN to add rd_active (last loaded preset) and
//   rd_wraps (saturating count of frames that wrapped, cleared only by reset).
module pf_vscroll_ctrl #(
  parameter int STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_we,
  input  logic [4*STAGES-1:0]   cpu_wdata,
  input  logic                  cpu_dir,
  input  logic                  vblank,
  input  logic                  line_tick,
  input  logic                  max_min,
  output logic                  load_n,
  output logic                  cten_n,
  output logic                  du,
  output logic [4*STAGES-1:0]   preset,
  output logic                  pending,
  output logic                  wrap_seen
`ifdef VSCROLL_READBACK_EN
  ,
  output logic [4*STAGES-1:0]   rd_active,
  output logic [7:0]            rd_wraps
`endif
);

  localparam int W = 4 * STAGES;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    RUN  = 2'd3
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic           vb_q;
  logic           rise;
  logic           fall;
  logic           tick_q;
  logic           enter_load;
  logic           wrap_hit;
  logic [W-1:0]   shadow;
  logic           shadow_dir;

  assign rise = vblank & ~vb_q;
  assign fall = ~vblank & vb_q;

  // preset/du are captured on the edge that enters LOAD so the chain sees
  // stable load data for the whole load_n=0 cycle. A write landing in the
  // LOAD cycle only reaches the shadow, so this frame keeps the old value.
  assign enter_load = ((state == IDLE) || (state == RUN)) && rise;

  assign wrap_hit = (state == RUN) && !cten_n && max_min;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rise) state_nxt = LOAD;
      LOAD:    state_nxt = WAIT;
      WAIT:    if (fall) state_nxt = RUN;
      RUN:     if (rise) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic. A vblank rise in RUN wins over a pending count pulse so the
  // chain is never counted in the same cycle it is about to be reloaded.
  always_comb begin
    load_n = 1'b1;
    cten_n = 1'b1;
    case (state)
      LOAD:    load_n = 1'b0;
      RUN:     if (tick_q && !rise) cten_n = 1'b0;
      default: ;
    endcase
  end

  // Datapath and status registers
  always_ff @(posedge clk) begin
    if (reset) begin
      vb_q       <= 1'b0;
      tick_q     <= 1'b0;
      shadow     <= '0;
      shadow_dir <= 1'b0;
      pending    <= 1'b0;
      preset     <= '0;
      du         <= 1'b0;
      wrap_seen  <= 1'b0;
    end else begin
      vb_q   <= vblank;
      // Ticks outside RUN (including WAIT) are dropped here.
      tick_q <= line_tick && (state == RUN);

      if (cpu_we) begin
        shadow     <= cpu_wdata;
        shadow_dir <= cpu_dir;
      end

      // A write coinciding with a load still leaves a value outstanding.
      if (cpu_we) begin
        pending <= 1'b1;
      end else if (enter_load) begin
        pending <= 1'b0;
      end

      if (enter_load) begin
        preset    <= shadow;
        du        <= shadow_dir;
        wrap_seen <= 1'b0;
      end else if (wrap_hit) begin
        wrap_seen <= 1'b1;
      end
    end
  end

`ifdef VSCROLL_READBACK_EN
  assign rd_active = preset;

  // Counts frames, not wrap cycles: only the first hit of a frame increments.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_wraps <= 8'd0;
    end else if (wrap_hit && !wrap_seen && (rd_wraps != 8'hFF)) begin
      rd_wraps <= rd_wraps + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pf_vscroll_ctrl.sv
// Bench for pf_vscroll_ctrl: frame-level reference model feeds an expected
// event queue (load and count pulses, tagged with cycle number); a negedge
// monitor pops and compares whenever the DUT asserts load_n or cten_n.
module tb_pf_vscroll_ctrl;

  localparam int STAGES = 2;
  localparam int W = 4 * STAGES;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cpu_we = 1'b0;
  logic [W-1:0]  cpu_wdata = '0;
  logic          cpu_dir = 1'b0;
  logic          vblank = 1'b0;
  logic          line_tick = 1'b0;
  logic          max_min = 1'b0;
  logic          load_n;
  logic          cten_n;
  logic          du;
  logic [W-1:0]  preset;
  logic          pending;
  logic          wrap_seen;
`ifdef VSCROLL_READBACK_EN
  logic [W-1:0]  rd_active;
  logic [7:0]    rd_wraps;
`endif

  pf_vscroll_ctrl #(.STAGES(STAGES)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_we    (cpu_we),
    .cpu_wdata (cpu_wdata),
    .cpu_dir   (cpu_dir),
    .vblank    (vblank),
    .line_tick (line_tick),
    .max_min   (max_min),
    .load_n    (load_n),
    .cten_n    (cten_n),
    .du        (du),
    .preset    (preset),
    .pending   (pending),
    .wrap_seen (wrap_seen)
`ifdef VSCROLL_READBACK_EN
    ,
    .rd_active (rd_active),
    .rd_wraps  (rd_wraps)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Expected pulse events.
  typedef struct {
    logic         is_load;
    int           at;
    logic [W-1:0] val;
    logic         dir;
  } ev_t;
  ev_t exp_q[$];

  // Frame phases as seen on the chain: idle, loading, waiting for end of
  // vblank, and counting lines.
  typedef enum int {P_IDLE, P_LOAD, P_WAIT, P_RUN} phase_t;

  // Reference model: frame phase + CPU shadow + visible status per cycle.
  phase_t       phase, nxt_phase;
  logic [W-1:0] m_shadow;
  logic         m_dir;
  logic         m_vb;
  logic         tick_prev;
  logic [W-1:0] vis_preset, nxt_preset;
  logic         vis_du, nxt_du;
  logic         vis_pending, nxt_pending;
  logic         vis_wrap, nxt_wrap;
  int           vis_wraps, nxt_wraps;
  logic         mon_en = 1'b0;
  int           n_load_seen = 0;
  int           n_cten_seen = 0;

  task automatic model_reset();
    nxt_phase = P_IDLE;
    m_shadow = '0; m_dir = 1'b0; m_vb = 1'b0; tick_prev = 1'b0;
    nxt_preset = '0; nxt_du = 1'b0; nxt_pending = 1'b0; nxt_wrap = 1'b0;
    nxt_wraps = 0;
  endtask

  // One clock cycle of stimulus; updates the model and queues expectations.
  task automatic step(input logic we, input logic [W-1:0] wd, input logic dir,
                      input logic vb, input logic tick, input logic mm);
    logic rise, fall, pulse;
    @(posedge clk); #1;
    phase = nxt_phase;
    vis_preset = nxt_preset; vis_du = nxt_du; vis_pending = nxt_pending;
    vis_wrap = nxt_wrap; vis_wraps = nxt_wraps;
    mon_en = 1'b1;
    reset = 1'b0;
    cpu_we = we; cpu_wdata = wd; cpu_dir = dir;
    vblank = vb; line_tick = tick; max_min = mm;

    rise = vb && !m_vb;
    fall = !vb && m_vb;
    m_vb = vb;
    // A line tick yields a count pulse one cycle later, unless the frame
    // restarts in that cycle.
    pulse = tick_prev && (phase == P_RUN) && !rise;
    if (pulse) exp_q.push_back('{1'b0, cyc, vis_preset, vis_du});
    tick_prev = tick && (phase == P_RUN);

    if (pulse && mm && !vis_wrap) begin
      nxt_wrap = 1'b1;
      if (nxt_wraps < 255) nxt_wraps = nxt_wraps + 1;
    end

    case (phase)
      P_IDLE, P_RUN: if (rise) begin
        nxt_phase = P_LOAD;
        nxt_preset = m_shadow; nxt_du = m_dir;
        nxt_pending = 1'b0; nxt_wrap = 1'b0;
        exp_q.push_back('{1'b1, cyc + 1, m_shadow, m_dir});
      end
      P_LOAD: nxt_phase = P_WAIT;
      P_WAIT: if (fall) nxt_phase = P_RUN;
      default: ;
    endcase

    if (we) begin
      m_shadow = wd; m_dir = dir; nxt_pending = 1'b1;
    end
  endtask

  task automatic idle(input int n, input logic vb);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, vb, 1'b0, 1'b0);
  endtask

  // Monitor: status levels every cycle, and event-by-event pulse matching.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("pending", pending, vis_pending);
      chk("wrap_seen", wrap_seen, vis_wrap);
      chk("preset_level", preset, vis_preset);
      chk("du_level", du, vis_du);
`ifdef VSCROLL_READBACK_EN
      chk("rd_wraps", rd_wraps, vis_wraps);
      chk("rd_active", rd_active, vis_preset);
`endif
      if (!load_n || !cten_n) begin
        ev_t e;
        if (!load_n) n_load_seen++;
        if (!cten_n) n_cten_seen++;
        chk("load_and_cten_overlap", {31'd0, load_n | cten_n}, 32'd1);
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse_load_n", {31'd0, load_n}, 32'd1);
          chk("unexpected_pulse_cten_n", {31'd0, cten_n}, 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_kind_is_load", {31'd0, !load_n}, {31'd0, e.is_load});
          chk("pulse_cycle", cyc, e.at);
          if (e.is_load) begin
            chk("load_preset", preset, e.val);
            chk("load_du", du, e.dir);
          end
        end
      end
    end
  end

  logic [11:0] pat;
  int base;

  initial begin
    // 1. Reset for two clocks.
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_load_n", load_n, 1); chk("rst_cten_n", cten_n, 1);
    chk("rst_du", du, 0); chk("rst_preset", preset, 0);
    chk("rst_pending", pending, 0); chk("rst_wrap_seen", wrap_seen, 0);
    model_reset();

    // 2. Write 3C up, then vblank rise; ticks during LOAD/WAIT are ignored.
    base = n_load_seen;
    step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1, 1'b0);
    chk("pending_after_write", pending, 1);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("one_load_3c", n_load_seen - base, 1);
    chk("preset_3c", preset, 8'h3C);
    chk("pending_cleared", pending, 0);

    // 3. Fall, then 5 ticks with one adjacent pair.
    base = n_cten_seen;
    pat = 12'b100110100100;
    idle(1, 1'b0);
    for (int i = 11; i >= 0; i--) step(1'b0, '0, 1'b0, 1'b0, pat[i], 1'b0);
    idle(2, 1'b0);
    chk("five_ctens", n_cten_seen - base, 5);

    // 4. Mid-RUN write 10/down; no effect until the next load.
    step(1'b1, 8'h10, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("preset_held_mid_run", preset, 8'h3C);
    chk("du_held_mid_run", du, 0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);       // tick, then rise: pulse suppressed
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1, 1'b1);
    chk("preset_10", preset, 8'h10);
    chk("du_down", du, 1);

    // 5. Write 55 exactly in the LOAD cycle.
    idle(3, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);       // rise
    step(1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0);    // LOAD cycle
    idle(1, 1'b1);
    chk("load_used_old", preset, 8'h10);
    chk("pending_kept", pending, 1);
    idle(3, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1, 1'b1);
    chk("preset_55", preset, 8'h55);
    chk("du_up_55", du, 0);

    // 6. Wrap during a count pulse, held until next load.
    idle(2, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);       // pulse cycle with max_min
    idle(3, 1'b0);
    chk("wrap_set", wrap_seen, 1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);       // max_min without pulse
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1, 1'b1);
    chk("wrap_cleared_by_load", wrap_seen, 0);

    // Randomized traffic.
    begin
      logic vb;
      vb = 1'b1;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 11) == 0) vb = ~vb;
        step(($urandom_range(0, 9) == 0), W'($urandom), 1'($urandom),
             vb, ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0));
      end
    end

`ifdef VSCROLL_READBACK_EN
    // 300 wrapping frames saturate the frame-wrap counter.
    for (int f = 0; f < 300; f++) begin
      idle(1, 1'b0);
      step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(1, 1'b1);
      step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    idle(2, 1'b0);
    chk("rd_wraps_saturated", rd_wraps, 255);
`endif

    // Remaining expectations must all have been matched.
    idle(2, 1'b0);
    chk("queue_drained", exp_q.size(), 0);

    // Reset mid-frame aborts a pending count pulse.
    idle(1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(2, 1'b1);
    idle(2, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    mon_en = 1'b0;
    line_tick = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("reset_aborts_cten", cten_n, 1);
    chk("reset_clears_preset", preset, 0);
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
